// File: rtl/dfr_pkg.sv
// Shared DFR definitions: argmax FSM states, row-major address helper and
// the default Z dimensions used by both the multiplier and the argmax block.
package dfr_pkg;

    localparam int unsigned DFR_Z_ROWS = 5;
    localparam int unsigned DFR_Z_COLS = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_FINAL = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic int unsigned row_major_addr(input int unsigned row,
                                                   input int unsigned col,
                                                   input int unsigned cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/matrix_argmax_if.sv
// RAM-side bus of matrix_argmax: Z RAM read port and class-index RAM write port.
interface matrix_argmax_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] z_addr;
    logic [DATA_WIDTH-1:0] z_data;
    logic [ADDR_WIDTH-1:0] idx_addr;
    logic [DATA_WIDTH-1:0] idx_data;
    logic                  idx_wen;

    modport master (output z_addr, input z_data, output idx_addr, output idx_data, output idx_wen);
    modport slave  (input z_addr, output z_data, input idx_addr, input idx_data, input idx_wen);
endinterface

// File: rtl/argmax_compare.sv
// Strict greater-than of a Z element against the running best.
// MATRIX_ARGMAX_SIGNED_EN selects two's-complement instead of unsigned compare.
module argmax_compare #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  gt_c
);
`ifdef MATRIX_ARGMAX_SIGNED_EN
    assign gt_c = $signed(a) > $signed(b);
`else
    assign gt_c = a > b;
`endif
endmodule

// File: rtl/matrix_argmax.sv
// Row-wise argmax of Z: reads Z row-major, writes the max column index per row.
// Compare signedness follows MATRIX_ARGMAX_SIGNED_EN (see argmax_compare).
module matrix_argmax
    import dfr_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned Z_ROWS     = DFR_Z_ROWS,
    parameter int unsigned Z_COLS     = DFR_Z_COLS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    matrix_argmax_if.master bus,
    output logic            busy,
    output logic            done
);

    localparam int unsigned COL_W = (Z_COLS > 1) ? $clog2(Z_COLS) : 1;
    localparam int unsigned ROW_W = (Z_ROWS > 1) ? $clog2(Z_ROWS) : 1;

    state_t                state, state_n;
    logic [ROW_W-1:0]      row, row_n;
    logic [COL_W-1:0]      col, col_n;
    logic [DATA_WIDTH-1:0] best_val, best_val_n;
    logic [COL_W-1:0]      best_idx, best_idx_n;
    logic [ADDR_WIDTH-1:0] z_addr, z_addr_n;
    logic [ADDR_WIDTH-1:0] idx_addr, idx_addr_n;
    logic [DATA_WIDTH-1:0] idx_data, idx_data_n;
    logic                  idx_wen, idx_wen_n;
    logic                  busy_n, done_n;

    logic                  gt_c;
    logic                  data_vld_c;
    logic [COL_W-1:0]      data_col_c;
    logic                  take_c;

    argmax_compare #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
        .a    (bus.z_data),
        .b    (best_val),
        .gt_c (gt_c)
    );

    // z_data always belongs to the column addressed one cycle earlier
    assign data_col_c = (state == ST_FINAL) ? COL_W'(Z_COLS - 1) : col - COL_W'(1);
    assign data_vld_c = (state == ST_FINAL) || ((state == ST_READ) && (col != '0));
    assign take_c     = data_vld_c && ((data_col_c == '0) || gt_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            row      <= '0;
            col      <= '0;
            best_val <= '0;
            best_idx <= '0;
            z_addr   <= '0;
            idx_addr <= '0;
            idx_data <= '0;
            idx_wen  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            row      <= row_n;
            col      <= col_n;
            best_val <= best_val_n;
            best_idx <= best_idx_n;
            z_addr   <= z_addr_n;
            idx_addr <= idx_addr_n;
            idx_data <= idx_data_n;
            idx_wen  <= idx_wen_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        row_n      = row;
        col_n      = col;
        best_val_n = best_val;
        best_idx_n = best_idx;
        z_addr_n   = z_addr;
        idx_addr_n = idx_addr;
        idx_data_n = idx_data;
        idx_wen_n  = 1'b0;
        busy_n     = busy;
        done_n     = 1'b0;

        if (take_c) begin
            best_val_n = bus.z_data;
            best_idx_n = data_col_c;
        end

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n  = ST_READ;
                    row_n    = '0;
                    col_n    = '0;
                    z_addr_n = '0;
                    busy_n   = 1'b1;
                end
            end
            ST_READ: begin
                if (col == COL_W'(Z_COLS - 1)) begin
                    state_n = ST_FINAL;
                end else begin
                    col_n    = col + COL_W'(1);
                    z_addr_n = ADDR_WIDTH'(row_major_addr(32'(row), 32'(col) + 32'd1, Z_COLS));
                end
            end
            ST_FINAL: begin
                state_n    = ST_WRITE;
                idx_wen_n  = 1'b1;
                idx_addr_n = ADDR_WIDTH'(row);
                idx_data_n = DATA_WIDTH'(best_idx_n);
            end
            ST_WRITE: begin
                if (row == ROW_W'(Z_ROWS - 1)) begin
                    state_n = ST_DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    state_n  = ST_READ;
                    row_n    = row + ROW_W'(1);
                    col_n    = '0;
                    z_addr_n = ADDR_WIDTH'(row_major_addr(32'(row) + 32'd1, 32'd0, Z_COLS));
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign bus.z_addr   = z_addr;
    assign bus.idx_addr = idx_addr;
    assign bus.idx_data = idx_data;
    assign bus.idx_wen  = idx_wen;

endmodule

// File: tb/tb_matrix_argmax.sv
// Self-checking bench for matrix_argmax: 5x5 instance with a scoreboard of
// expected index writes, plus a 1x1 instance for the degenerate dimensions.
module tb_matrix_argmax;

    logic clk = 1'b0;
    logic rst;
    logic start, start1;
    logic busy, done, busy1, done1;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int done_count = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] z_mem [0:31];
    logic [31:0] z_one;

    always #5 clk = ~clk;

    matrix_argmax_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    matrix_argmax_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

    matrix_argmax #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .Z_ROWS(5), .Z_COLS(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus0),
        .busy  (busy),
        .done  (done)
    );

    matrix_argmax #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .Z_ROWS(1), .Z_COLS(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .bus   (bus1),
        .busy  (busy1),
        .done  (done1)
    );

    // Z RAMs with one cycle read latency
    always @(posedge clk) bus0.z_data <= z_mem[bus0.z_addr[4:0]];
    always @(posedge clk) bus1.z_data <= z_one;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit greater(input logic [31:0] a, input logic [31:0] b);
`ifdef MATRIX_ARGMAX_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    function automatic logic [31:0] ref_argmax(input int r);
        int best = 0;
        for (int c = 1; c < 5; c++)
            if (greater(z_mem[r*5+c], z_mem[r*5+best])) best = c;
        return 32'(best);
    endfunction

    task automatic load_row(input int r, input logic [31:0] v0, input logic [31:0] v1,
                            input logic [31:0] v2, input logic [31:0] v3, input logic [31:0] v4);
        z_mem[r*5+0] = v0;
        z_mem[r*5+1] = v1;
        z_mem[r*5+2] = v2;
        z_mem[r*5+3] = v3;
        z_mem[r*5+4] = v4;
    endtask

    task automatic load_matrix_a();
        load_row(0, 1, 9, 3, 4, 2);
        load_row(1, 7, 0, 0, 0, 0);
        load_row(2, 0, 0, 0, 0, 8);
        load_row(3, 5, 5, 5, 5, 5);
        load_row(4, 1, 2, 3, 4, 5);
    endtask

    task automatic push_exp(input int r, input logic [31:0] d);
        exp_t e;
        e.addr = 32'(r);
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Pulse start at the current negedge; wait (bounded) for done.
    task automatic run(input int pulse_at, output int busy_n, output int done_at);
        busy_n  = 0;
        done_at = -1;
        start   = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            start = (k == pulse_at);
            if (busy) busy_n++;
            if (done) begin
                done_at = k - 1;
                break;
            end
        end
        start = 1'b0;
    endtask

    // Index-RAM write monitor: pops the scoreboard on every write
    always @(negedge clk) begin
        if (!rst) begin
            if (bus0.idx_wen) begin
                wr_count++;
                check("write_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("idx_addr", 64'(bus0.idx_addr), 64'(e.addr));
                    check("idx_data", 64'(bus0.idx_data), 64'(e.data));
                end
            end
            if (done) done_count++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, da;
        rst    = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        z_one  = 32'd42;
        for (int i = 0; i < 32; i++) z_mem[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_z_addr",   64'(bus0.z_addr),   64'd0);
        check("rst_idx_addr", 64'(bus0.idx_addr), 64'd0);
        check("rst_idx_data", 64'(bus0.idx_data), 64'd0);
        check("rst_idx_wen",  64'(bus0.idx_wen),  64'd0);
        check("rst_busy",     64'(busy),          64'd0);
        check("rst_done",     64'(done),          64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed matrix from the test plan
        load_matrix_a();
        push_exp(0, 1); push_exp(1, 0); push_exp(2, 4); push_exp(3, 0); push_exp(4, 4);
        wr_count = 0; done_count = 0;
        run(0, bc, da);
        @(negedge clk);
        check("a_done_latency", 64'(da), 64'd35);
        check("a_busy_cycles",  64'(bc), 64'd35);
        check("a_writes",       64'(wr_count), 64'd5);
        check("a_done_count",   64'(done_count), 64'd1);
        check("a_done_pulse",   64'(done), 64'd0);
        check("a_queue_empty",  64'(exp_q.size()), 64'd0);

        // Ties, sign-sensitive row, random rows; extra start mid-run is ignored
        load_row(0, 3, 8, 8, 2, 8);
        load_row(1, 32'hFFFF_FFFF, 1, 0, 0, 0);
        for (int i = 10; i < 25; i++) z_mem[i] = $urandom;
        push_exp(0, 1);
`ifdef MATRIX_ARGMAX_SIGNED_EN
        push_exp(1, 1);
`else
        push_exp(1, 0);
`endif
        for (int r = 2; r < 5; r++) push_exp(r, ref_argmax(r));
        wr_count = 0; done_count = 0;
        run(10, bc, da);
        check("b_done_latency", 64'(da), 64'd35);
        check("b_busy_cycles",  64'(bc), 64'd35);
        repeat (10) @(negedge clk);
        check("b_writes",       64'(wr_count), 64'd5);
        check("b_done_count",   64'(done_count), 64'd1);
        check("b_idle_after",   64'(busy), 64'd0);
        check("b_queue_empty",  64'(exp_q.size()), 64'd0);

        // Reset in the middle of row 1: only row 0 gets written
        load_matrix_a();
        push_exp(0, 1);
        wr_count = 0; done_count = 0;
        start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("mrst_z_addr",   64'(bus0.z_addr),   64'd0);
        check("mrst_idx_addr", 64'(bus0.idx_addr), 64'd0);
        check("mrst_idx_data", 64'(bus0.idx_data), 64'd0);
        check("mrst_idx_wen",  64'(bus0.idx_wen),  64'd0);
        check("mrst_busy",     64'(busy),          64'd0);
        check("mrst_done",     64'(done),          64'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("mrst_writes",      64'(wr_count), 64'd1);
        check("mrst_done_count",  64'(done_count), 64'd0);
        check("mrst_queue_empty", 64'(exp_q.size()), 64'd0);

        // Fresh random run after the reset
        for (int i = 0; i < 25; i++) z_mem[i] = $urandom;
        z_mem[7] = z_mem[5];
        for (int r = 0; r < 5; r++) push_exp(r, ref_argmax(r));
        wr_count = 0; done_count = 0;
        run(0, bc, da);
        @(negedge clk);
        check("c_done_latency", 64'(da), 64'd35);
        check("c_writes",       64'(wr_count), 64'd5);
        check("c_done_count",   64'(done_count), 64'd1);
        check("c_queue_empty",  64'(exp_q.size()), 64'd0);

        // 1x1 instance: write of 0 at address 0 on cycle 3, done on cycle 4
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("one_busy",     64'(busy1), 64'd1);
        check("one_wen_c1",   64'(bus1.idx_wen), 64'd0);
        @(negedge clk);
        check("one_wen_c2",   64'(bus1.idx_wen), 64'd0);
        @(negedge clk);
        check("one_wen",      64'(bus1.idx_wen), 64'd1);
        check("one_idx_addr", 64'(bus1.idx_addr), 64'd0);
        check("one_idx_data", 64'(bus1.idx_data), 64'd0);
        check("one_done_c3",  64'(done1), 64'd0);
        @(negedge clk);
        check("one_done",     64'(done1), 64'd1);
        check("one_busy_end", 64'(busy1), 64'd0);
        check("one_wen_end",  64'(bus1.idx_wen), 64'd0);
        @(negedge clk);
        check("one_done_pulse", 64'(done1), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
